// File: rtl/ring_nic.sv
// ring_nic: NIC between a CMP node's processor port and its ring router PE port.
// One-entry input and output channel buffers; injection is gated by the VC bit against ring polarity.
module ring_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam logic [ADDR_WIDTH-1:0] A_IN_BUF   = ADDR_WIDTH'(2'd0);
  localparam logic [ADDR_WIDTH-1:0] A_IN_STAT  = ADDR_WIDTH'(2'd1);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_BUF  = ADDR_WIDTH'(2'd2);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_STAT = ADDR_WIDTH'(2'd3);

  logic [0:DATA_WIDTH-1] r_in_buf;
  logic                  r_in_full;
  logic [0:DATA_WIDTH-1] r_out_buf;
  logic                  r_out_full;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_ring_take;
  logic                  w_in_pop;
  logic                  w_out_push;
  logic                  w_vc_match;
  logic                  w_net_so;
  logic                  w_net_ri;
  logic [0:DATA_WIDTH-1] w_in_status;
  logic [0:DATA_WIDTH-1] w_out_status;

  // Status flags land in bit DATA_WIDTH-1, the LSB under MSB-first numbering.
  assign w_in_status  = {{(DATA_WIDTH-1){1'b0}}, r_in_full};
  assign w_out_status = {{(DATA_WIDTH-1){1'b0}}, r_out_full};

  assign w_rd        = nicEn & ~nicWrEn & ~reset;
  assign w_wr        = nicEn &  nicWrEn & ~reset;
  assign w_net_ri    = ~reset & ~r_in_full;
  assign w_ring_take = net_si & w_net_ri;
  assign w_in_pop    = w_rd & (addr == A_IN_BUF) & r_in_full;
  // A write racing a drain sees the pre-drain full flag and is dropped.
  assign w_out_push  = w_wr & (addr == A_OUT_BUF) & ~r_out_full;
  assign w_vc_match  = (r_out_buf[0] == net_polarity);
  assign w_net_so    = ~reset & r_out_full & net_ro & w_vc_match;

  assign net_ri = w_net_ri;
  assign net_so = w_net_so;
  assign net_do = r_out_buf;

  // Processor read mux; zero when idle, writing or in reset.
  always_comb begin
    d_out = {DATA_WIDTH{1'b0}};
    if (w_rd) begin
      case (addr)
        A_IN_BUF:   d_out = r_in_buf;
        A_IN_STAT:  d_out = w_in_status;
        A_OUT_BUF:  d_out = r_out_buf;
        A_OUT_STAT: d_out = w_out_status;
        default:    d_out = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      d_out = {DATA_WIDTH{1'b0}};
    end
  end

  // Input channel: ring capture and processor pop are mutually exclusive on the full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_buf  <= {DATA_WIDTH{1'b0}};
      r_in_full <= 1'b0;
    end else if (w_ring_take) begin
      r_in_buf  <= net_di;
      r_in_full <= 1'b1;
    end else if (w_in_pop) begin
      r_in_full <= 1'b0;
    end
  end

  // Output channel: ring drain and processor push are mutually exclusive on the full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_buf  <= {DATA_WIDTH{1'b0}};
      r_out_full <= 1'b0;
    end else if (w_net_so) begin
      r_out_full <= 1'b0;
    end else if (w_out_push) begin
      r_out_buf  <= d_in;
      r_out_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_nic.sv
// Self-checking bench for ring_nic: directed vector table, a polarity-wait sequence,
// then randomized traffic against a queue-based reference model.
module tb_ring_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [63:0] d_in = 64'd0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [63:0] net_di = 64'd0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_polarity = 1'b0;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  ring_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  typedef struct {
    logic        rst, en, wr;
    logic [1:0]  a;
    logic [63:0] din;
    logic        si;
    logic [63:0] di;
    logic        ro, pol;
    logic        e_ri, e_so;
    logic        c_dout;
    logic [63:0] e_dout;
    logic        c_do;
    logic [63:0] e_do;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, en, wr, input logic [1:0] a, input logic [63:0] din,
                       input logic si, input logic [63:0] di, input logic ro, pol);
    reset = rst; nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
  endtask

  task automatic add(input logic rst, en, wr, input logic [1:0] a, input logic [63:0] din,
                     input logic si, input logic [63:0] di, input logic ro, pol,
                     input logic e_ri, e_so, c_dout, input logic [63:0] e_dout,
                     input logic c_do, input logic [63:0] e_do);
    vec_t v;
    v.rst = rst; v.en = en; v.wr = wr; v.a = a; v.din = din; v.si = si; v.di = di;
    v.ro = ro; v.pol = pol; v.e_ri = e_ri; v.e_so = e_so; v.c_dout = c_dout;
    v.e_dout = e_dout; v.c_do = c_do; v.e_do = e_do;
    vecs.push_back(v);
  endtask

  // Reference model: each channel is a queue of capacity one plus the last value held.
  logic [63:0] m_in_q[$];
  logic [63:0] m_out_q[$];
  logic [63:0] m_in_last  = 64'd0;
  logic [63:0] m_out_last = 64'd0;

  localparam logic [63:0] PKT_D  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] PKT_P  = 64'h8000_0000_0000_00AA;
  localparam logic [63:0] PKT_77 = 64'h0000_0000_0000_0077;
  localparam logic [63:0] PKT_B  = 64'h8000_0000_0000_0BBB;
  localparam logic [63:0] PKT_C  = 64'h8000_0000_0000_0CCC;
  localparam logic [63:0] PKT_I  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] Z      = 64'd0;
  localparam logic [63:0] ONE    = 64'd1;

  initial begin
    // rst en wr a  din  si di ro pol | ri so cd dout cdo do
    add(1,1,0,2'd1,Z,1,PKT_D,0,0, 0,0,1,Z,0,Z);
    add(1,0,0,2'd0,Z,0,Z,0,1,     0,0,1,Z,0,Z);
    add(0,0,0,2'd0,Z,0,Z,0,0,     1,0,1,Z,0,Z);
    add(0,1,0,2'd1,Z,0,Z,0,1,     1,0,1,Z,0,Z);
    add(0,1,0,2'd3,Z,0,Z,0,0,     1,0,1,Z,0,Z);
    add(0,0,0,2'd0,Z,1,PKT_D,0,1, 1,0,1,Z,0,Z);
    add(0,1,0,2'd1,Z,1,64'h5555,0,0, 0,0,1,ONE,0,Z);
    add(0,1,0,2'd0,Z,1,64'h5555,0,1, 0,0,1,PKT_D,0,Z);
    add(0,1,0,2'd1,Z,0,Z,0,0,     1,0,1,Z,0,Z);
    add(0,1,0,2'd0,Z,0,Z,0,1,     1,0,1,PKT_D,0,Z);
    add(0,1,1,2'd2,PKT_P,0,Z,1,0, 1,0,0,Z,0,Z);
    add(0,1,0,2'd3,Z,0,Z,1,0,     1,0,1,ONE,1,PKT_P);
    add(0,1,0,2'd2,Z,0,Z,1,1,     1,1,1,PKT_P,1,PKT_P);
    add(0,1,0,2'd3,Z,0,Z,1,0,     1,0,1,Z,0,Z);
    add(0,0,0,2'd0,Z,0,Z,1,1,     1,0,1,Z,0,Z);
    add(0,1,1,2'd2,PKT_77,0,Z,0,0, 1,0,0,Z,0,Z);
    add(0,1,1,2'd2,64'h1234,0,Z,0,1, 1,0,0,Z,1,PKT_77);
    add(0,1,0,2'd2,Z,0,Z,0,0,     1,0,1,PKT_77,0,Z);
    add(0,1,0,2'd3,Z,0,Z,0,1,     1,0,1,ONE,0,Z);
    add(0,1,0,2'd2,Z,0,Z,0,0,     1,0,1,PKT_77,0,Z);
    add(0,0,0,2'd0,Z,0,Z,0,1,     1,0,1,Z,1,PKT_77);
    add(0,1,0,2'd2,Z,0,Z,1,1,     1,0,1,PKT_77,0,Z);
    add(0,1,1,2'd2,PKT_B,0,Z,1,0, 1,1,0,Z,1,PKT_77);
    add(0,1,0,2'd3,Z,0,Z,1,1,     1,0,1,Z,0,Z);
    add(0,1,1,2'd2,PKT_B,0,Z,0,0, 1,0,0,Z,0,Z);
    add(0,1,0,2'd2,Z,0,Z,0,1,     1,0,1,PKT_B,1,PKT_B);
    add(0,0,0,2'd0,Z,1,PKT_I,0,0, 1,0,1,Z,0,Z);
    add(1,1,0,2'd0,Z,0,Z,1,1,     0,0,1,Z,0,Z);
    add(0,1,0,2'd1,Z,0,Z,1,1,     1,0,1,Z,0,Z);
    add(0,1,0,2'd3,Z,0,Z,1,0,     1,0,1,Z,0,Z);
    add(0,1,0,2'd2,Z,0,Z,1,1,     1,0,1,Z,1,Z);
    add(0,1,0,2'd0,Z,0,Z,1,0,     1,0,1,Z,0,Z);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].en, vecs[i].wr, vecs[i].a, vecs[i].din,
            vecs[i].si, vecs[i].di, vecs[i].ro, vecs[i].pol);
      #2;
      chk($sformatf("vec%0d net_ri", i), {63'd0, net_ri}, {63'd0, vecs[i].e_ri});
      chk($sformatf("vec%0d net_so", i), {63'd0, net_so}, {63'd0, vecs[i].e_so});
      if (vecs[i].c_dout) chk($sformatf("vec%0d d_out", i), d_out, vecs[i].e_dout);
      if (vecs[i].c_do)   chk($sformatf("vec%0d net_do", i), net_do, vecs[i].e_do);
    end

    // Polarity wait: a VC=1 packet written in a polarity-0 cycle leaves within two cycles.
    begin
      int  waited;
      logic seen;
      @(negedge clk);
      drive(0,1,1,2'd2,PKT_C,0,Z,1,0);
      waited = 0;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
        @(negedge clk);
        drive(0,0,0,2'd0,Z,0,Z,1,(k % 2 == 0) ? 1'b1 : 1'b0);
        #2;
        waited++;
        if (net_so) begin
          seen = 1'b1;
          chk("polwait net_do", net_do, PKT_C);
        end
      end
      chk("polwait emitted", {63'd0, seen}, ONE);
      chk("polwait latency", 64'(waited), 64'd1);
      @(negedge clk);
      drive(0,1,0,2'd3,Z,0,Z,1,1);
      #2;
      chk("polwait status", d_out, Z);
      chk("polwait no_repeat", {63'd0, net_so}, Z);
      m_out_last = PKT_C;
    end

    // Randomized traffic against the reference model.
    begin
      logic rst, en, wr, si, ro, pol;
      logic [1:0]  a;
      logic [63:0] din, di, e_dout;
      logic e_ri, e_so, take, pop, push;
      pol = 1'b0;
      for (int i = 0; i < 600; i++) begin
        rst = (i == 0) || ($urandom_range(0, 63) == 0);
        en  = ($urandom_range(0, 3) != 0);
        wr  = ($urandom_range(0, 2) == 0);
        a   = (wr && $urandom_range(0, 1) == 1) ? 2'd2 : 2'($urandom_range(0, 3));
        din = {$urandom, $urandom};
        si  = ($urandom_range(0, 1) == 1);
        di  = {$urandom, $urandom};
        ro  = ($urandom_range(0, 3) != 0);
        pol = ~pol;
        @(negedge clk);
        drive(rst, en, wr, a, din, si, di, ro, pol);

        e_ri = !rst && (m_in_q.size() == 0);
        e_so = !rst && (m_out_q.size() == 1) && ro && (m_out_q[0][63] == pol);
        if (rst || !en) e_dout = Z;
        else case (a)
          2'd0:    e_dout = m_in_last;
          2'd1:    e_dout = (m_in_q.size() != 0) ? ONE : Z;
          2'd2:    e_dout = m_out_last;
          default: e_dout = (m_out_q.size() != 0) ? ONE : Z;
        endcase
        #2;
        chk($sformatf("rnd%0d net_ri", i), {63'd0, net_ri}, {63'd0, e_ri});
        chk($sformatf("rnd%0d net_so", i), {63'd0, net_so}, {63'd0, e_so});
        chk($sformatf("rnd%0d net_do", i), net_do, m_out_last);
        if (rst || !en || !wr) chk($sformatf("rnd%0d d_out", i), d_out, e_dout);

        @(posedge clk);
        if (rst) begin
          m_in_q.delete();
          m_out_q.delete();
          m_in_last  = Z;
          m_out_last = Z;
        end else begin
          take = si && e_ri;
          pop  = en && !wr && (a == 2'd0) && (m_in_q.size() != 0);
          push = en && wr && (a == 2'd2) && (m_out_q.size() == 0);
          if (pop) void'(m_in_q.pop_front());
          if (take) begin
            m_in_q.push_back(di);
            m_in_last = di;
          end
          if (e_so) void'(m_out_q.pop_front());
          if (push) begin
            m_out_q.push_back(din);
            m_out_last = din;
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ring_nic.md
Name: ring_nic

Overview:
- Network interface controller for one CMP node.
- Sits between the node's processor (memory-mapped NIC port) and its ring router's PE port.
- Holds one 64-bit input channel buffer (ring→processor) and one 64-bit output channel buffer (processor→ring), each with a full flag.
- Injection into the ring is gated by the packet's virtual-channel bit against the global ring polarity.

Parameters:
- DATA_WIDTH, 64, packet and data bus width; bit 0 is the MSB, using [0:DATA_WIDTH-1] ordering.
- ADDR_WIDTH, 2, processor-side register address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  input  64  processor write data.
- d_out  output  64  processor read data.
- nicEn  input  1  processor access enable.
- nicWrEn  input  1  1 = write, 0 = read; valid only when nicEn=1.
- net_si  input  1  ring offers a packet to this NIC.
- net_ri  output  1  NIC can accept a packet from the ring.
- net_di  input  64  packet from the ring.
- net_so  output  1  NIC offers a packet to the ring.
- net_ro  input  1  ring can accept a packet from the NIC.
- net_do  output  64  packet to the ring.
- net_polarity  input  1  global ring polarity; toggles every cycle.

Behaviour:
- State: in_buf[0:63], in_full, out_buf[0:63], out_full.
- Reset (reset=1 at the edge): in_full=0, out_full=0, in_buf=0, out_buf=0.
- While reset=1: net_ri=0, net_so=0, d_out=0, all inputs ignored.
- The first ring transfer can occur on the cycle after reset deasserts.
- Ring→NIC handshake:
  - net_ri = ~in_full (combinational; 0 during reset).
  - When net_si & net_ri at an edge: in_buf←net_di, in_full←1.
  - When net_si=1 and net_ri=0, the packet is not taken. The ring holds it; no drop.
- Processor read (nicEn=1, nicWrEn=0), d_out combinational:
  - addr 00: d_out=in_buf. If in_full=1, in_full←0 at the edge. A read with in_full=0 returns the stale in_buf and changes no state.
  - addr 01: d_out={63'b0, in_full}, i.e. the status is in bit 63.
  - addr 10: d_out=out_buf.
  - addr 11: d_out={63'b0, out_full}.
- nicEn=0: d_out=0.
- Processor write (nicEn=1, nicWrEn=1):
  - addr 10 with out_full=0: out_buf←d_in, out_full←1.
  - addr 10 with out_full=1: write dropped; out_buf is unchanged. Software must poll addr 11 first.
  - Writes to addr 00, 01 or 11: ignored.
- NIC→ring handshake:
  - net_do = out_buf (combinational).
  - net_so = out_full & net_ro & (out_buf[0] == net_polarity), combinational. out_buf[0] is the VC bit.
  - The transfer completes on an edge with net_so=1, and out_full←0 at that edge.
  - If the VC does not match, the NIC waits for the next polarity phase (at most 1 extra cycle while net_ro stays high).
- Simultaneous events:
  - Ring delivery and processor read in the same cycle cannot both hit: net_ri=0 while full. The read clears in_full, and net_ri=1 on the next cycle.
  - Processor write to addr 10 in the same cycle the buffer drains: the write is dropped, because out_full was still 1 at the decision. The next cycle's write succeeds.
  - Independent channels: input and output buffers may update in the same edge.
- Reset mid-operation: any buffered packet is discarded and both full flags clear, regardless of pending handshakes.
- Latency:
  - Ring→processor-visible: 1 cycle (status=1 on the cycle after capture).
  - Processor write → net_so possible: 1 cycle.

Test Plan:
- Reset, then idle → net_ri=1, net_so=0, d_out=0; read addr 01 → 64'h0, read addr 11 → 64'h0.
- Ring delivery: net_si=1, net_di=64'hDEAD_BEEF_0000_0001 → next cycle net_ri=0 and status 01 reads 64'h1. Read addr 00 → returns DEAD_BEEF_0000_0001; the following cycle net_ri=1 and status reads 0. A second net_si while full is held off (net_ri=0) and not captured.
- Injection with polarity: write addr 10, d_in=64'h8000_0000_0000_00AA (VC=1), net_ro=1, net_polarity alternating 0,1 → net_so=1 only in the polarity=1 cycle with net_do=8000_0000_0000_00AA; out_full clears; status 11 reads 0 afterwards.
- Backpressure: out_full=1, net_ro=0 for 5 cycles → net_so stays 0 and out_buf is held. A second write of 64'h1234 is dropped (addr 10 still reads the first packet). Raising net_ro gives a single transfer.
- Simultaneous drain + write: a write to addr 10 in the same cycle as the net_so transfer → write dropped, out_full=0 next cycle; repeating the write one cycle later → accepted.
- Reset mid-operation: both buffers full, assert reset for 1 cycle → in_full=out_full=0, net_ri=1 and net_so=0 after reset deasserts; no packet is emitted.
